// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FMA issue scheduler: op codes and the tagged result record.
package fpu_sched_pkg;

  localparam logic [1:0] OP_MADD  = 2'b00;  // a*b+c
  localparam logic [1:0] OP_MSUB  = 2'b01;  // a*b-c
  localparam logic [1:0] OP_NMADD = 2'b10;  // -(a*b)+c
  localparam logic [1:0] OP_NMSUB = 2'b11;  // -(a*b)-c

  localparam int unsigned RSP_TAG_W = 8;

  typedef struct packed {
    logic [RSP_TAG_W-1:0] tag;
    logic [31:0]          data;
  } tagged_res_t;

endpackage

// File: rtl/fma_rsp_fifo.sv
// In-order synchronous response FIFO; the head entry is presented straight from the storage registers.
module fma_rsp_fifo #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + AW'(1);
    end
  endfunction

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign rdata = mem_r[rd_ptr_r];

  // qualify push/pop against the flags
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // storage array
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/fma_rsp_fifo_chk.sv
// Checker for the response FIFO: the credit counter must make a push into a full FIFO impossible.
module fma_rsp_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fma_issue_sched.sv
// Round-robin issue scheduler for the shared FMA datapath with owner-tag tracking and a
// credit-protected in-order response FIFO.
module fma_issue_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned TW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*32-1:0] req_c,
  input  logic [NREQ*2-1:0] req_op,
  output logic              fma_valid,
  output logic [31:0]       fma_a,
  output logic [31:0]       fma_b,
  output logic [31:0]       fma_c,
  output logic [1:0]        fma_op,
  input  logic [31:0]       fma_res,
  output logic              rsp_valid,
  output logic [TW-1:0]     rsp_tag,
  output logic [31:0]       rsp_data,
  input  logic              rsp_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]  cnt_r;
  logic [TW-1:0]  rr_r;
  logic [TW-1:0]  grant_s;
  logic [TW-1:0]  idx_s;
  logic           grant_any_s;
  logic           credit_ok_s;
  logic           accept_s;
  logic           pop_s;
  logic [TW-1:0]  issue_tag_r;
  logic           pipe_vld_r [LAT];
  logic [TW-1:0]  pipe_tag_r [LAT];
  logic [TW+31:0] fifo_wdata_s;
  logic [TW+31:0] fifo_rdata_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;

  // round-robin search, scanned from the farthest offset so the lane nearest rr wins
  always_comb begin
    grant_s     = '0;
    grant_any_s = 1'b0;
    idx_s       = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx_s = rr_r + TW'(k);
      if (req_valid[idx_s]) begin
        grant_s     = idx_s;
        grant_any_s = 1'b1;
      end else begin
        grant_s     = grant_s;
        grant_any_s = grant_any_s;
      end
    end
  end

  // credit gate and handshake decode; reset holds every ready low
  always_comb begin
    credit_ok_s = (cnt_r < CW'(DEPTH)) && !rst;
    if (grant_any_s && credit_ok_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
    end else begin
      req_ready = '0;
    end
    accept_s = |(req_valid & req_ready);
    pop_s    = rsp_valid & rsp_ready;
  end

  // credit counter: in-flight plus queued results
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r <= '0;
    end else if (accept_s) begin
      rr_r <= grant_s + TW'(1);
    end
  end

  // issue register; operands hold between issues
  always_ff @(posedge clk) begin
    if (rst) begin
      fma_valid   <= 1'b0;
      fma_a       <= 32'd0;
      fma_b       <= 32'd0;
      fma_c       <= 32'd0;
      fma_op      <= 2'b00;
      issue_tag_r <= '0;
    end else if (accept_s) begin
      fma_valid   <= 1'b1;
      fma_a       <= req_a[{grant_s, 5'd0} +: 32];
      fma_b       <= req_b[{grant_s, 5'd0} +: 32];
      fma_c       <= req_c[{grant_s, 5'd0} +: 32];
      fma_op      <= req_op[{grant_s, 1'b0} +: 2];
      issue_tag_r <= grant_s;
    end else begin
      fma_valid   <= 1'b0;
    end
  end

  // tag pipe shadows the datapath so the tail lines up with fma_res
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(LAT); k++) begin
        pipe_vld_r[k] <= 1'b0;
        pipe_tag_r[k] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= fma_valid;
      pipe_tag_r[0] <= issue_tag_r;
      for (int k = 1; k < int'(LAT); k++) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        pipe_tag_r[k] <= pipe_tag_r[k-1];
      end
    end
  end

  assign fifo_wdata_s = {pipe_tag_r[LAT-1], fma_res};

  fma_rsp_fifo #(
    .W     (TW + 32),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_vld_r[LAT-1]),
    .wdata (fifo_wdata_s),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  fma_rsp_fifo_chk u_rsp_fifo_chk (
    .clk  (clk),
    .rst  (rst),
    .push (pipe_vld_r[LAT-1]),
    .full (fifo_full_s)
  );

  assign rsp_valid = !fifo_empty_s;
  assign rsp_tag   = fifo_rdata_s[TW+31:32];
  assign rsp_data  = fifo_rdata_s[31:0];

endmodule

// File: tb/tb_fma_issue_sched.sv
// Self-checking bench for fma_issue_sched: datapath model, response scoreboard, vector table
// and directed multi-cycle sequences.
module tb_fma_issue_sched;
  import fpu_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a, req_b, req_c;
  logic [NREQ*2-1:0] req_op;
  logic              fma_valid;
  logic [31:0]       fma_a, fma_b, fma_c, fma_res;
  logic [1:0]        fma_op;
  logic              rsp_valid;
  logic [TW-1:0]     rsp_tag;
  logic [31:0]       rsp_data;
  logic              rsp_ready;

  fma_issue_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_op(req_op),
    .fma_valid(fma_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_op(fma_op),
    .fma_res(fma_res), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // single-precision <-> real for normal numbers and zero
  function automatic real s2r(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fma_model(input logic [31:0] a, b, c, input logic [1:0] op);
    real p, rc, r;
    p  = s2r(a) * s2r(b);
    rc = s2r(c);
    case (op)
      OP_MADD:  r = p + rc;
      OP_MSUB:  r = p - rc;
      OP_NMADD: r = -p + rc;
      default:  r = -p - rc;
    endcase
    return r2s(r);
  endfunction

  // datapath model: fixed latency, poison value when nothing was issued
  logic [31:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= fma_valid ? fma_model(fma_a, fma_b, fma_c, fma_op) : 32'hFFC0_0001;
    for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign fma_res = dp_pipe[LAT-1];

  // scoreboard and handshake monitor
  tagged_res_t sb_q[$];
  int          grant_q[$];
  int          acc_count = 0;
  logic        acc_seen_n = 1'b0;
  int          acc_lane_n = 0;
  logic        prev_acc = 1'b0;
  logic [31:0] prev_a, prev_b, prev_c;
  logic [1:0]  prev_op;
  logic        oneshot [NREQ];

  always @(negedge clk) begin
    tagged_res_t e;
    acc_seen_n = 1'b0;
    if (rst) begin
      sb_q.delete();
      prev_acc = 1'b0;
    end else begin
      check("fma_valid", fma_valid, prev_acc);
      if (prev_acc) begin
        check("fma_a", fma_a, prev_a);
        check("fma_b", fma_b, prev_b);
        check("fma_c", fma_c, prev_c);
        check("fma_op", fma_op, prev_op);
      end
      check("ready_onehot", $onehot0(req_ready), 1'b1);
      check("ready_without_valid", req_ready & ~req_valid, 0);
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rsp_tag", rsp_tag, e.tag[TW-1:0]);
          check("rsp_data", rsp_data, e.data);
        end
      end
      prev_acc = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.tag  = RSP_TAG_W'(i);
          e.data = fma_model(req_a[32*i +: 32], req_b[32*i +: 32], req_c[32*i +: 32], req_op[2*i +: 2]);
          sb_q.push_back(e);
          grant_q.push_back(i);
          acc_count++;
          prev_acc   = 1'b1;
          prev_a     = req_a[32*i +: 32];
          prev_b     = req_b[32*i +: 32];
          prev_c     = req_c[32*i +: 32];
          prev_op    = req_op[2*i +: 2];
          acc_seen_n = 1'b1;
          acc_lane_n = i;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (acc_seen_n && oneshot[acc_lane_n]) req_valid[acc_lane_n] = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, b, c, input logic [1:0] op);
    req_a[32*l +: 32] = a;
    req_b[32*l +: 32] = b;
    req_c[32*l +: 32] = c;
    req_op[2*l +: 2]  = op;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((sb_q.size() != 0 || rsp_valid) && n < 60) begin
      step();
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  typedef struct {
    int          lane;
    logic [31:0] a, b, c;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int pos;
    int cnt_l [NREQ];
    logic [TW-1:0] hold_tag;
    logic [31:0]   hold_data;

    vecs[0] = '{2, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b00, 32'h40E0_0000};
    vecs[1] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b01, 32'h40A0_0000};
    vecs[2] = '{1, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b10, 32'hC0A0_0000};
    vecs[3] = '{3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b11, 32'hC0E0_0000};
    vecs[4] = '{2, 32'h3FC0_0000, 32'h4080_0000, 32'h3F00_0000, 2'b00, 32'h40D0_0000};
    vecs[5] = '{1, 32'h0000_0000, 32'h40A0_0000, 32'h4000_0000, 2'b00, 32'h4000_0000};

    for (int i = 0; i < NREQ; i++) begin
      oneshot[i] = 1'b1;
      set_lane(i, 32'h3F80_0000 + 32'(i << 20), 32'h4000_0000, 32'h3F80_0000, 2'(i));
    end

    // reset state, with every lane requesting
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '1;
    step();
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_fma_valid", fma_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fma_a", fma_a, 0);
    check("rst_fma_op", fma_op, 0);
    req_valid = '0;
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();

    // vector table: single requests, latency and result
    for (int i = 0; i < 6; i++) begin
      set_lane(vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op);
      req_valid[vecs[i].lane] = 1'b1;
      #1;
      check("vec_req_ready", req_ready, 64'(1) << vecs[i].lane);
      step();
      check("vec_fma_valid", fma_valid, 1'b1);
      check("vec_fma_a", fma_a, vecs[i].a);
      check("vec_fma_op", fma_op, vecs[i].op);
      n = 1;
      while (!rsp_valid && n < 30) begin
        step();
        n++;
      end
      check("vec_latency", n, LAT + 2);
      check("vec_rsp_tag", rsp_tag, vecs[i].lane);
      check("vec_rsp_data", rsp_data, vecs[i].exp);
      step();
    end
    drain();

    // all four lanes at once from rr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    grant_q.delete();
    req_valid = '1;
    repeat (4) step();
    check("simul_grants", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) check("simul_grant_order", grant_q[i], i);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check("simul_rsp_valid", rsp_valid, 1'b1);
      check("simul_rsp_tag", rsp_tag, i);
      step();
    end
    drain();

    // credit exhaustion, hold stability and no same-cycle bypass
    oneshot[0] = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    acc_count = 0;
    repeat (20) step();
    check("credit_accepts", acc_count, DEPTH);
    check("credit_ready_low", req_ready, 0);
    hold_tag  = rsp_tag;
    hold_data = rsp_data;
    step();
    check("hold_tag", rsp_tag, hold_tag);
    check("hold_data", rsp_data, hold_data);
    rsp_ready = 1'b1;
    #1;
    check("credit_no_bypass", req_ready, 0);
    step();
    rsp_ready = 1'b0;
    acc_count = 0;
    repeat (6) step();
    check("credit_one_more", acc_count, 1);
    drain();

    // accept and pop together at cnt=5
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (5) step();
    req_valid = '0;
    repeat (LAT + 3) step();
    set_lane(1, 32'h4080_0000, 32'h4080_0000, 32'h3F80_0000, 2'b01);
    req_valid[1] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("popiss_ready", req_ready, 4'b0010);
    acc_count = 0;
    step();
    rsp_ready = 1'b0;
    req_valid[0] = 1'b1;
    repeat (15) step();
    check("popiss_accepts", acc_count, 4);
    drain();

    // fairness: lane 3 joins a continuously requesting lane 0
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    repeat (3) step();
    grant_q.delete();
    req_valid[3] = 1'b1;
    pos = -1;
    n = 0;
    while (pos < 0 && n < 10) begin
      step();
      n++;
      foreach (grant_q[j]) if (grant_q[j] == 3 && pos < 0) pos = j;
    end
    check("fair_lane3_found", pos >= 0, 1'b1);
    check("fair_lane3_within2", pos <= 1, 1'b1);
    drain();

    // fairness: three lanes held, sustained issue shares grants evenly
    oneshot[1] = 1'b0;
    oneshot[3] = 1'b0;
    grant_q.delete();
    req_valid = 4'b1011;
    repeat (9) step();
    req_valid = '0;
    check("rr_throughput", grant_q.size(), 9);
    for (int i = 0; i < NREQ; i++) cnt_l[i] = 0;
    foreach (grant_q[j]) cnt_l[grant_q[j]]++;
    check("rr_lane0", cnt_l[0], 3);
    check("rr_lane1", cnt_l[1], 3);
    check("rr_lane3", cnt_l[3], 3);
    drain();
    for (int i = 0; i < NREQ; i++) oneshot[i] = 1'b1;

    // reset with three operations in flight
    oneshot[2] = 1'b0;
    req_valid = 4'b0100;
    repeat (3) step();
    req_valid = '0;
    step();
    rst = 1'b1;
    req_valid[1] = 1'b1;
    #1;
    check("midrst_ready", req_ready, 0);
    step();
    req_valid = '0;
    rst = 1'b0;
    check("midrst_fma_valid", fma_valid, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_fma_a", fma_a, 0);
    check("midrst_fma_op", fma_op, 0);
    pos = 0;
    repeat (LAT + 4) begin
      step();
      if (rsp_valid) pos = 1;
    end
    check("midrst_no_stale_rsp", pos, 0);
    set_lane(1, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'b00);
    req_valid[1] = 1'b1;
    step();
    n = 1;
    while (!rsp_valid && n < 30) begin
      step();
      n++;
    end
    check("midrst_new_latency", n, LAT + 2);
    check("midrst_new_tag", rsp_tag, 1);
    check("midrst_new_data", rsp_data, 32'h40E0_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fma_issue_sched.md
# fma_issue_sched

Round-robin issue scheduler and result return unit for the shared fused multiply-add datapath in the vector FPU (align, multiply, add stage, normalise). It arbitrates up to NREQ lane requesters onto the single FMA pipeline, which has a fixed latency and never stalls. It tracks each in-flight operation's owner tag alongside the pipeline. Completed results go into a credit-protected in-order response FIFO so that output backpressure never overflows the datapath.

## Interface
- NREQ, 4: number of requesters; power of two, 2 or more. TW = clog2(NREQ).
- LAT, 4: FMA datapath latency in cycles from fma_valid to fma_res, 1 or more.
- DEPTH, 8: response FIFO depth and credit limit; 2 or more. CW = clog2(DEPTH+1).
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-lane request valid.
- req_ready  out  NREQ  per-lane accept; one-hot or zero.
- req_a, req_b, req_c  in  NREQ*32 each  single-precision operands; lane i occupies bits [32i+31:32i].
- req_op  in  NREQ*2  per lane: 00 a*b+c, 01 a*b-c, 10 -(a*b)+c, 11 -(a*b)-c.
- fma_valid  out  1  registered issue strobe to the datapath.
- fma_a, fma_b, fma_c  out  32 each  registered operands.
- fma_op  out  2  registered op code.
- fma_res  in  32  datapath result; valid exactly LAT cycles after the matching fma_valid.
- rsp_valid  out  1  response available.
- rsp_tag  out  TW  owning requester index.
- rsp_data  out  32  result.
- rsp_ready  in  1  response consumer accept.

## Operation
- **Credit counter cnt (CW bits):** counts in-flight operations plus FIFO occupancy.
  - Issue is allowed only when cnt < DEPTH. There is no same-cycle bypass from a pop.
  - Accept increments cnt. Pop (rsp_valid & rsp_ready) decrements cnt. Both in one cycle leaves cnt unchanged.
- **Arbiter:** round-robin over req_valid, starting at pointer rr.
  - Grant goes to the first valid lane at or after rr, modulo NREQ.
  - req_ready[i] is high only for the granted lane, and only when credit is available. It is combinational from req_valid, rr and cnt.
  - On accept, rr becomes grant+1 (mod NREQ). Without an accept, rr holds.
- **Handshake:** a transfer happens when req_valid[i] & req_ready[i]. A requester holds valid and operands stable until it is accepted. Deasserting valid before acceptance is legal and simply withdraws the request.
- **Issue register:** on accept, the granted lane's operands, op and tag are latched and fma_valid is set for one cycle. Otherwise fma_valid is 0 and the operand registers hold.
- **Tag pipe:** a LAT-deep shift register of {valid, tag}, loaded from the issue register. When the tail is valid, fma_res is pushed into the FIFO together with the tail tag.
- **FIFO:** in order, registered output. rsp_valid = !empty. rsp_tag and rsp_data show the head entry.
  - Overflow is impossible by construction of the credit counter. A push into a full FIFO is an assertion error.
- **Reset:** clears cnt, rr, all tag-pipe valids, the FIFO pointers, fma_valid and fma_a/b/c/op to 0. Therefore rsp_valid = 0 and req_ready = 0 during reset.
  - Operations in flight at reset are discarded. Datapath outputs that appear after reset are ignored because the pipe valids are 0.

## Timing
- Accept in cycle t gives fma_valid in t+1, fma_res sampled in t+1+LAT, and rsp_valid in t+2+LAT. Minimum accept-to-response latency is LAT+2.
- Sustained throughput is one issue per cycle when rsp_ready is held high and DEPTH ≥ LAT+2. Smaller DEPTH throttles issue via the credit counter.
- A push and a pop in the same cycle are both performed. Occupancy is unchanged and ordering is preserved.
- When rsp_ready is low, a held response keeps rsp_tag and rsp_data stable.

## Structure
- Package fpu_sched_pkg holds the op-code localparams (OP_MADD, OP_MSUB, OP_NMADD, OP_NMSUB) and the tagged-result struct {tag, data}.
- Sub-module fma_rsp_fifo: a parameterised synchronous FIFO of width TW+32 and depth DEPTH, with registered output, full/empty flags and synchronous active-high reset.
- Arbiter, credit counter, issue register and tag pipe live in the top module.

## Test plan
- **Single request:** lane 2 request with a=2.0, b=3.0, c=1.0, op=00, rsp_ready=1 -> fma_valid one cycle later; with the datapath model, rsp_valid at t+6 (LAT=4), rsp_tag=2, rsp_data=0x40E00000.
- **Simultaneous requests:** all four lanes valid at t with rr=0 -> grants 0,1,2,3 in t..t+3; responses return tagged 0,1,2,3 in order on consecutive cycles.
- **Credit exhaustion:** rsp_ready=0, lane 0 always valid -> exactly 8 accepts, then req_ready=0. Raising rsp_ready for one cycle gives one pop and permits exactly one further accept in the following cycle.
- **Simultaneous pop and issue:** at cnt=5, accept and pop in the same cycle -> cnt stays 5, no response is lost or reordered.
- **Fairness:** lane 0 continuously valid, lane 3 asserts at t -> lane 3 is granted within 2 accepts. Grant order never starves any lane.
- **Reset mid-flight:** three operations in flight, rst pulsed one cycle -> all outputs 0 after the reset edge, no rsp_valid from the old operations, and a new request completes normally.
